avalon_st_packetizer: RTL and testbench
=======================================

# avalon_st_packetizer

Downstream consumer of the 8-bit Avalon-ST byte stream produced by the test-design streaming FIFO. It groups incoming bytes into fixed-length packets and emits a header byte carrying a 4-bit sequence number, then the payload. It can optionally append an XOR checksum byte. The output is Avalon-ST with start/end-of-packet framing and ready latency 0, for use by packet-aware cocotb drivers and monitors.

## Interface
- PAYLOAD_LEN, 4, payload bytes per packet; legal range 1..256
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- asi_valid  in  1  upstream byte valid
- asi_data  in  8  upstream byte
- asi_ready  out  1  upstream ready; combinational, ready latency 0
- aso_valid  out  1  output beat valid (registered)
- aso_data  out  8  output byte (registered)
- aso_startofpacket  out  1  high on the header beat (registered)
- aso_endofpacket  out  1  high on the last beat of a packet (registered)
- aso_ready  in  1  downstream ready, ready latency 0

## Operation
- Output register holds one beat. It loads when `free = !aso_valid || aso_ready`. When it is not loading and aso_ready=1, aso_valid clears.
- FSM states:
  - HEADER
    - If free && asi_valid: load {4'hA, seq[3:0]} with sop=1 and eop=0.
    - cnt<=0, chk<=0, go to PAYLOAD.
    - No input byte is consumed. The header is never emitted without a pending input byte.
  - PAYLOAD
    - asi_ready = free. On asi_valid && asi_ready: load asi_data with sop=0, chk<=chk^asi_data, cnt<=cnt+1.
    - When cnt==PAYLOAD_LEN-1 the beat is the last payload byte. Next state is CHECKSUM if checksum is enabled. Otherwise eop=1 on this beat, seq<=seq+1, next state HEADER.
  - CHECKSUM (only when enabled)
    - If free: load chk with eop=1, seq<=seq+1, go to HEADER.
- asi_ready=0 in HEADER and CHECKSUM.
- cnt is $clog2(PAYLOAD_LEN+1) bits. seq is 4 bits and wraps 15→0.
- chk is the XOR of this packet's payload bytes only; the header is excluded.
- PAYLOAD_LEN=1: a single payload beat carries eop, or is followed by the checksum beat.
- Holding: while aso_valid && !aso_ready, aso_data, sop and eop stay stable and no input is consumed.

## Timing
- Reset values:
  - aso_valid=0, aso_data=8'h00, aso_startofpacket=0, aso_endofpacket=0
  - state=HEADER, seq=0, cnt=0, chk=0
  - asi_ready=0 while reset=1
- Reset mid-packet: the partial packet is abandoned and no eop is emitted. The first packet after reset carries seq 0.
- Latency: with asi_valid=1 in cycle N (HEADER, free), the header is valid at N+1. The first payload byte is consumed at N+1 if aso_ready=1, and appears at N+2.
- Throughput with aso_ready tied high:
  - PAYLOAD_LEN+1 cycles per packet without checksum.
  - PAYLOAD_LEN+2 cycles per packet with checksum.
- Simultaneous aso_ready and new load: back-to-back beats with no bubble.

## Configuration
- AVALON_PACKETIZER_CHECKSUM_EN
  - Defined: CHECKSUM state is compiled in. Each packet is header + PAYLOAD_LEN bytes + XOR checksum byte, and eop is on the checksum beat.
  - Undefined: CHECKSUM state and chk register are absent. eop is on the last payload byte.

## Test plan
- Basic framing, PAYLOAD_LEN=4, no checksum: feed 11,22,33,44 with aso_ready=1. Require output A0(sop), 11, 22, 33, 44(eop) on 5 consecutive cycles.
- Checksum enabled, same input: require A0(sop), 11, 22, 33, 44, 44(eop). The checksum is 11^22^33^44=44.
- Sequence wrap: send 17 packets. Header bytes must run A0..AF, then A0 on packet 17.
- Backpressure:
  - Drop aso_ready for 3 cycles while byte 22 is presented. Require aso_data=22 held stable, asi_ready=0 throughout, and no byte lost or duplicated.
  - Random aso_ready and asi_valid patterns must reproduce the scoreboard stream exactly.
- Reset mid-packet: assert reset for 1 cycle after bytes 11 and 22. Require aso_valid=0 the cycle after reset, then feed 55,66,77,88. Require A0(sop), 55, 66, 77, 88(eop).
- PAYLOAD_LEN=1: feed 5A, then 3C. Require A0(sop), 5A(eop), A1(sop), 3C(eop). With checksum enabled, a 5A beat and a 3C beat are inserted before each eop.

Source files
------------

// File: rtl/avalon_st_packetizer_if.sv
// Avalon-ST byte-in / packet-out handshake bundle for avalon_st_packetizer.
// slave is the packetizer's view; master is the view of whatever drives it.
interface avalon_st_packetizer_if;
    logic       asi_valid;
    logic [7:0] asi_data;
    logic       asi_ready;
    logic       aso_valid;
    logic [7:0] aso_data;
    logic       aso_startofpacket;
    logic       aso_endofpacket;
    logic       aso_ready;

    modport master (
        output asi_valid, asi_data, aso_ready,
        input  asi_ready, aso_valid, aso_data, aso_startofpacket, aso_endofpacket
    );

    modport slave (
        input  asi_valid, asi_data, aso_ready,
        output asi_ready, aso_valid, aso_data, aso_startofpacket, aso_endofpacket
    );
endinterface

// File: rtl/avalon_st_packetizer.sv
// Groups an Avalon-ST byte stream into header+payload packets with a 4-bit sequence number.
// Define AVALON_PACKETIZER_CHECKSUM_EN to append an XOR checksum beat carrying eop.
module avalon_st_packetizer #(
    parameter int PAYLOAD_LEN = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    avalon_st_packetizer_if.slave  st
);
    localparam int CNT_W = $clog2(PAYLOAD_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAYLOAD_LEN - 1);

    localparam logic [1:0] ST_HEADER   = 2'd0;
    localparam logic [1:0] ST_PAYLOAD  = 2'd1;
`ifdef AVALON_PACKETIZER_CHECKSUM_EN
    localparam logic [1:0] ST_CHECKSUM = 2'd2;
`endif

    logic [1:0]       state_q, state_d;
    logic [3:0]       seq_q, seq_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef AVALON_PACKETIZER_CHECKSUM_EN
    logic [7:0]       chk_q, chk_d;
`endif
    logic             aso_valid_q, aso_valid_d;
    logic [7:0]       aso_data_q, aso_data_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;

    logic             free;
    logic             asi_ready;

    // The single output beat register may take a new beat when empty or draining this cycle.
    assign free      = !aso_valid_q || st.aso_ready;
    assign asi_ready = !reset && (state_q == ST_PAYLOAD) && free;

    assign st.asi_ready         = asi_ready;
    assign st.aso_valid         = aso_valid_q;
    assign st.aso_data          = aso_data_q;
    assign st.aso_startofpacket = sop_q;
    assign st.aso_endofpacket   = eop_q;

    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        cnt_d       = cnt_q;
`ifdef AVALON_PACKETIZER_CHECKSUM_EN
        chk_d       = chk_q;
`endif
        aso_valid_d = aso_valid_q;
        aso_data_d  = aso_data_q;
        sop_d       = sop_q;
        eop_d       = eop_q;

        // A free register that is not reloaded below ends up empty.
        if (free) begin
            aso_valid_d = 1'b0;
        end

        case (state_q)
            ST_HEADER: begin
                // Header only goes out once a payload byte is waiting, so no orphan headers.
                if (free && st.asi_valid) begin
                    aso_valid_d = 1'b1;
                    aso_data_d  = {4'hA, seq_q};
                    sop_d       = 1'b1;
                    eop_d       = 1'b0;
                    cnt_d       = '0;
`ifdef AVALON_PACKETIZER_CHECKSUM_EN
                    chk_d       = 8'h00;
`endif
                    state_d     = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (st.asi_valid && asi_ready) begin
                    aso_valid_d = 1'b1;
                    aso_data_d  = st.asi_data;
                    sop_d       = 1'b0;
                    eop_d       = 1'b0;
                    cnt_d       = cnt_q + CNT_W'(1);
`ifdef AVALON_PACKETIZER_CHECKSUM_EN
                    chk_d       = chk_q ^ st.asi_data;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_CHECKSUM;
                    end
`else
                    if (cnt_q == CNT_LAST) begin
                        eop_d   = 1'b1;
                        seq_d   = seq_q + 4'd1;
                        state_d = ST_HEADER;
                    end
`endif
                end
            end
`ifdef AVALON_PACKETIZER_CHECKSUM_EN
            ST_CHECKSUM: begin
                if (free) begin
                    aso_valid_d = 1'b1;
                    aso_data_d  = chk_q;
                    sop_d       = 1'b0;
                    eop_d       = 1'b1;
                    seq_d       = seq_q + 4'd1;
                    state_d     = ST_HEADER;
                end
            end
`endif
            default: begin
                state_d = ST_HEADER;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HEADER;
            seq_q       <= 4'd0;
            cnt_q       <= '0;
`ifdef AVALON_PACKETIZER_CHECKSUM_EN
            chk_q       <= 8'h00;
`endif
            aso_valid_q <= 1'b0;
            aso_data_q  <= 8'h00;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            cnt_q       <= cnt_d;
`ifdef AVALON_PACKETIZER_CHECKSUM_EN
            chk_q       <= chk_d;
`endif
            aso_valid_q <= aso_valid_d;
            aso_data_q  <= aso_data_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
        end
    end
endmodule

// File: tb/tb_avalon_st_packetizer.sv
// Directed bench for avalon_st_packetizer (PAYLOAD_LEN=4 and PAYLOAD_LEN=1 instances).
// Expectations follow AVALON_PACKETIZER_CHECKSUM_EN the same way the design does.
module tb_avalon_st_packetizer;
    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    avalon_st_packetizer_if if4();
    avalon_st_packetizer_if if1();

    avalon_st_packetizer #(.PAYLOAD_LEN(4)) dut4 (.clk(clk), .reset(reset), .st(if4));
    avalon_st_packetizer #(.PAYLOAD_LEN(1)) dut1 (.clk(clk), .reset(reset), .st(if1));

`ifdef AVALON_PACKETIZER_CHECKSUM_EN
    localparam int BPP4 = 6;
    localparam bit CKS  = 1'b1;
`else
    localparam int BPP4 = 5;
    localparam bit CKS  = 1'b0;
`endif

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [7:0] inq[$];
    logic [9:0] beats[$];
    int         beat_cyc[$];
    logic [9:0] expq[$];
    logic       last_asi_ready = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, sample 1ns later, then wait for the next falling edge.
    task automatic applyStimulus(input bit sel, input bit vld_en, input bit rdy);
        if (!sel) begin
            if4.asi_valid = vld_en && (inq.size() > 0);
            if4.asi_data  = (inq.size() > 0) ? inq[0] : 8'h00;
            if4.aso_ready = rdy;
            if1.asi_valid = 1'b0;
            if1.asi_data  = 8'h00;
            if1.aso_ready = 1'b1;
        end else begin
            if1.asi_valid = vld_en && (inq.size() > 0);
            if1.asi_data  = (inq.size() > 0) ? inq[0] : 8'h00;
            if1.aso_ready = rdy;
            if4.asi_valid = 1'b0;
            if4.asi_data  = 8'h00;
            if4.aso_ready = 1'b1;
        end
        #1;
        if (!sel) begin
            last_asi_ready = if4.asi_ready;
            if (if4.asi_valid && if4.asi_ready) void'(inq.pop_front());
            if (if4.aso_valid && if4.aso_ready) begin
                beats.push_back({if4.aso_startofpacket, if4.aso_endofpacket, if4.aso_data});
                beat_cyc.push_back(cyc);
            end
        end else begin
            last_asi_ready = if1.asi_ready;
            if (if1.asi_valid && if1.asi_ready) void'(inq.pop_front());
            if (if1.aso_valid && if1.aso_ready) begin
                beats.push_back({if1.aso_startofpacket, if1.aso_endofpacket, if1.aso_data});
                beat_cyc.push_back(cyc);
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic clearScoreboard();
        beats.delete();
        beat_cyc.delete();
        expq.delete();
    endtask

    task automatic expPush(input bit s, input bit e, input logic [7:0] d);
        expq.push_back({s, e, d});
    endtask

    task automatic expPacket4(input logic [7:0] hdr, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] cks);
        expPush(1'b1, 1'b0, hdr);
        expPush(1'b0, 1'b0, b0);
        expPush(1'b0, 1'b0, b1);
        expPush(1'b0, 1'b0, b2);
        expPush(1'b0, !CKS, b3);
        if (CKS) expPush(1'b0, 1'b1, cks);
    endtask

    task automatic drain(input bit sel, input int n, input int budget, input bit rnd);
        for (int k = 0; k < budget && beats.size() < n; k++) begin
            applyStimulus(sel, rnd ? 1'($urandom_range(0, 1)) : 1'b1,
                               rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        end
        checkOutput("drain_in_budget", 32'(beats.size() >= n), 32'd1);
    endtask

    task automatic checkStream(input string tag);
        checkOutput({tag, "_count"}, 32'(beats.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < beats.size(); i++) begin
            checkOutput($sformatf("%s[%0d]", tag, i), 32'(beats[i]), 32'(expq[i]));
        end
    endtask

    initial begin
        int start_cyc;
        int guard;
        if4.asi_valid = 1'b0; if4.asi_data = 8'h00; if4.aso_ready = 1'b1;
        if1.asi_valid = 1'b0; if1.asi_data = 8'h00; if1.aso_ready = 1'b1;
        @(negedge clk);

        // Reset values
        reset = 1'b1;
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 1);
        checkOutput("rst_asi_ready", 32'(last_asi_ready), 32'd0);
        checkOutput("rst_valid4", 32'(if4.aso_valid), 32'd0);
        checkOutput("rst_data4", 32'(if4.aso_data), 32'h00);
        checkOutput("rst_sop4", 32'(if4.aso_startofpacket), 32'd0);
        checkOutput("rst_eop4", 32'(if4.aso_endofpacket), 32'd0);
        checkOutput("rst_valid1", 32'(if1.aso_valid), 32'd0);
        reset = 1'b0;

        // Basic framing with back-to-back beats
        clearScoreboard();
        inq = '{8'h11, 8'h22, 8'h33, 8'h44};
        expPacket4(8'hA0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44);
        start_cyc = cyc;
        drain(0, BPP4, 30, 0);
        checkStream("basic");
        for (int i = 0; i < beat_cyc.size(); i++) begin
            checkOutput($sformatf("basic_cycle[%0d]", i), 32'(beat_cyc[i]), 32'(start_cyc + 1 + i));
        end

        // Backpressure: hold byte 22 for three cycles
        clearScoreboard();
        inq = '{8'h11, 8'h22, 8'h33, 8'h44};
        expPacket4(8'hA1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44);
        guard = 0;
        while (!(if4.aso_valid && if4.aso_data == 8'h22) && guard < 20) begin
            applyStimulus(0, 1, 1);
            guard++;
        end
        checkOutput("bp_reached_22", 32'(guard < 20), 32'd1);
        for (int h = 0; h < 3; h++) begin
            applyStimulus(0, 1, 0);
            checkOutput($sformatf("bp_hold_data[%0d]", h), 32'(if4.aso_data), 32'h22);
            checkOutput($sformatf("bp_hold_valid[%0d]", h), 32'(if4.aso_valid), 32'd1);
            checkOutput($sformatf("bp_asi_ready[%0d]", h), 32'(last_asi_ready), 32'd0);
        end
        drain(0, BPP4, 30, 0);
        checkStream("bp");

        // Random valid/ready patterns over two packets
        clearScoreboard();
        inq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hF0, 8'h0F, 8'hAA, 8'h55};
        expPacket4(8'hA2, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
        expPacket4(8'hA3, 8'hF0, 8'h0F, 8'hAA, 8'h55, 8'h00);
        drain(0, 2 * BPP4, 400, 1);
        checkStream("rand");

        // Reset mid-packet after 11 and 22 have been consumed
        clearScoreboard();
        inq = '{8'h11, 8'h22};
        for (int k = 0; k < 10 && inq.size() > 0; k++) applyStimulus(0, 1, 1);
        checkOutput("mid_fed", 32'(inq.size()), 32'd0);
        inq.push_back(8'h33);
        reset = 1'b1;
        applyStimulus(0, 1, 1);
        reset = 1'b0;
        checkOutput("mid_rst_asi_ready", 32'(last_asi_ready), 32'd0);
        checkOutput("mid_rst_valid", 32'(if4.aso_valid), 32'd0);
        checkOutput("mid_rst_eop", 32'(if4.aso_endofpacket), 32'd0);
        inq.delete();
        clearScoreboard();
        inq = '{8'h55, 8'h66, 8'h77, 8'h88};
        expPacket4(8'hA0, 8'h55, 8'h66, 8'h77, 8'h88, 8'hCC);
        drain(0, BPP4, 30, 0);
        checkStream("after_rst");

        // Sequence wrap over 17 packets
        reset = 1'b1;
        applyStimulus(0, 0, 1);
        reset = 1'b0;
        clearScoreboard();
        for (int k = 0; k < 68; k++) inq.push_back(8'(k));
        drain(0, 17 * BPP4, 300, 0);
        checkOutput("wrap_count", 32'(beats.size()), 32'(17 * BPP4));
        for (int p = 0; p < 17; p++) begin
            if (p * BPP4 < beats.size()) begin
                checkOutput($sformatf("wrap_hdr[%0d]", p), 32'(beats[p * BPP4]),
                            32'({1'b1, 1'b0, 4'hA, 4'(p)}));
            end
        end
        if (beat_cyc.size() == 17 * BPP4) begin
            checkOutput("wrap_no_bubble", 32'(beat_cyc[17 * BPP4 - 1] - beat_cyc[0]), 32'(17 * BPP4 - 1));
        end

        // PAYLOAD_LEN=1 instance
        clearScoreboard();
        inq = '{8'h5A, 8'h3C};
        expPush(1'b1, 1'b0, 8'hA0);
        expPush(1'b0, !CKS, 8'h5A);
        if (CKS) expPush(1'b0, 1'b1, 8'h5A);
        expPush(1'b1, 1'b0, 8'hA1);
        expPush(1'b0, !CKS, 8'h3C);
        if (CKS) expPush(1'b0, 1'b1, 8'h3C);
        drain(1, expq.size(), 30, 0);
        checkStream("len1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
